// File: rtl/array_sel_pkg.sv
// Shared types and helpers for the streaming array selector.
// Width helpers keep the value/tag widths at least one bit wide.
package array_sel_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Value width for a table of 'size' bins.
    function automatic int vw(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Tag width for frames of up to 'k' entries.
    function automatic int iw(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // Entries are laid out as {tag, value}; value sits in the low bits.
    function automatic logic [31:0] ent_value(input logic [31:0] e, input int w);
        return e & ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] ent_tag(input logic [31:0] e, input int w, input int t);
        return (e >> w) & ((32'd1 << t) - 32'd1);
    endfunction

endpackage

// File: rtl/array_sel_lane_merge.sv
// Resolves one beat's lanes against the current hit mask.
// Produces per-bin write enable / write tag (and duplicate flags when
// ARRAY_SEL_DUP_DETECT_EN is defined). Purely combinational.
module array_sel_lane_merge
    import array_sel_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int K         = 8,
    parameter int LANES     = 2,
    parameter int LAST_WINS = 0,
    localparam int VW = vw(SIZE),
    localparam int IW = iw(K),
    localparam int EW = IW + VW
) (
    input  logic [LANES*EW-1:0]       in_data,
    input  logic [LANES-1:0]          lane_ok,
    input  logic [SIZE-1:0]           hit_mask,
    output logic [SIZE-1:0]           we,
    output logic [SIZE-1:0][IW-1:0]   wtag
`ifdef ARRAY_SEL_DUP_DETECT_EN
    ,
    output logic [SIZE-1:0]           dup
`endif
);

    logic [LANES-1:0][VW-1:0] lval;
    logic [LANES-1:0][IW-1:0] ltag;
    logic [SIZE-1:0]          acc;

    // Slice each lane into its value and tag fields.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lval[j] = VW'(ent_value(32'(in_data[j*EW +: EW]), VW));
            ltag[j] = IW'(ent_tag(32'(in_data[j*EW +: EW]), VW, IW));
        end
    end

    // Walk lanes in order (lane 0 earliest); acc tracks hits seen so far,
    // including those made by lower lanes in this same beat.
    always_comb begin
        acc  = hit_mask;
        we   = '0;
        wtag = '0;
`ifdef ARRAY_SEL_DUP_DETECT_EN
        dup  = '0;
`endif
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (lane_ok[j] && (lval[j] == VW'(i))) begin
                    if (acc[i]) begin
`ifdef ARRAY_SEL_DUP_DETECT_EN
                        dup[i] = 1'b1;
`endif
                        if (LAST_WINS != 0) begin
                            we[i]   = 1'b1;
                            wtag[i] = ltag[j];
                        end
                    end else begin
                        acc[i]  = 1'b1;
                        we[i]   = 1'b1;
                        wtag[i] = ltag[j];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/array_selector_seq.sv
// Streaming value->tag lookup table builder.
// IDLE --start--> LOAD --last beat--> DONE --out_ready--> IDLE.
// Optional feature macro: ARRAY_SEL_DUP_DETECT_EN adds dup_mask.
module array_selector_seq
    import array_sel_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int K         = 8,
    parameter int LANES     = 2,
    parameter int LAST_WINS = 0,
    localparam int VW = vw(SIZE),
    localparam int IW = iw(K),
    localparam int EW = IW + VW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*EW-1:0]   in_data,
    input  logic [LANES-1:0]      in_lane_en,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE*IW-1:0]    results,
    output logic [SIZE-1:0]       hit_mask,
    output logic                  overflow,
`ifdef ARRAY_SEL_DUP_DETECT_EN
    output logic [SIZE-1:0]       dup_mask,
`endif
    output logic                  busy
);

    localparam int CW = $clog2(K + 1);

    state_t                  state, nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [SIZE-1:0][IW-1:0] tbl;
    logic [SIZE-1:0]         hit;
    logic                    ovf;
    logic [LANES-1:0]        lane_ok;
    logic                    ovf_beat;
    logic                    xfer;
    logic [SIZE-1:0]         we;
    logic [SIZE-1:0][IW-1:0] wtag;
`ifdef ARRAY_SEL_DUP_DETECT_EN
    logic [SIZE-1:0]         dup_w;
    logic [SIZE-1:0]         dup_q;
`endif

    // Handshake/status outputs are decodes of the state register only.
    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign xfer      = in_valid && in_ready;
    assign results   = tbl;
    assign hit_mask  = hit;
    assign overflow  = ovf;
`ifdef ARRAY_SEL_DUP_DETECT_EN
    assign dup_mask  = dup_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start)             nxt = S_LOAD;
            S_LOAD:  if (xfer && in_last)   nxt = S_DONE;
            S_DONE:  if (out_ready)         nxt = S_IDLE;
            default:                        nxt = S_IDLE;
        endcase
    end

    // Give each enabled lane its cumulative frame index; lanes at or past K
    // are dropped and flag overflow. The count saturates at K.
    always_comb begin
        int idx;
        idx      = int'(cnt);
        lane_ok  = '0;
        ovf_beat = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            if (in_lane_en[j]) begin
                if (idx < K) lane_ok[j] = 1'b1;
                else         ovf_beat   = 1'b1;
                idx++;
            end
        end
        cnt_nxt = (idx > K) ? CW'(K) : CW'(idx);
    end

    array_sel_lane_merge #(
        .SIZE      (SIZE),
        .K         (K),
        .LANES     (LANES),
        .LAST_WINS (LAST_WINS)
    ) u_merge (
        .in_data  (in_data),
        .lane_ok  (lane_ok),
        .hit_mask (hit),
        .we       (we),
        .wtag     (wtag)
`ifdef ARRAY_SEL_DUP_DETECT_EN
        ,
        .dup      (dup_w)
`endif
    );

    // Table, hit mask, overflow and count: cleared on start, updated per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= '0;
            hit <= '0;
            ovf <= 1'b0;
            cnt <= '0;
`ifdef ARRAY_SEL_DUP_DETECT_EN
            dup_q <= '0;
`endif
        end else if (state == S_IDLE && start) begin
            tbl <= '0;
            hit <= '0;
            ovf <= 1'b0;
            cnt <= '0;
`ifdef ARRAY_SEL_DUP_DETECT_EN
            dup_q <= '0;
`endif
        end else if (xfer) begin
            for (int i = 0; i < SIZE; i++)
                if (we[i]) tbl[i] <= wtag[i];
            hit <= hit | we;
            ovf <= ovf | ovf_beat;
            cnt <= cnt_nxt;
`ifdef ARRAY_SEL_DUP_DETECT_EN
            dup_q <= dup_q | dup_w;
`endif
        end
    end

endmodule

// File: tb/tb_array_selector_seq.sv
// Directed + randomized bench for array_selector_seq with a sequential
// entry-by-entry reference model of the table.
module tb_array_selector_seq;

    localparam int SIZE = 16, K = 8, LANES = 2, LW = 0;
    localparam int VW = 4, IW = 3, EW = IW + VW;

    logic                  clk, rst_n, start, in_valid, in_last, out_ready;
    logic                  in_ready, out_valid, overflow, busy;
    logic [LANES*EW-1:0]   in_data;
    logic [LANES-1:0]      in_lane_en;
    logic [SIZE*IW-1:0]    results;
    logic [SIZE-1:0]       hit_mask;
`ifdef ARRAY_SEL_DUP_DETECT_EN
    logic [SIZE-1:0]       dup_mask;
`endif

    array_selector_seq #(.SIZE(SIZE), .K(K), .LANES(LANES), .LAST_WINS(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lane_en(in_lane_en), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .results(results), .hit_mask(hit_mask), .overflow(overflow),
`ifdef ARRAY_SEL_DUP_DETECT_EN
        .dup_mask(dup_mask),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entries applied one at a time in arrival order.
    int ref_tag [SIZE];
    bit ref_hit [SIZE];
    bit ref_dup [SIZE];
    int ref_cnt;
    bit ref_ovf;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < SIZE; i++) begin
            ref_tag[i] = 0; ref_hit[i] = 0; ref_dup[i] = 0;
        end
        ref_cnt = 0; ref_ovf = 0;
    endtask

    task automatic model_beat(input logic [LANES*EW-1:0] d, input logic [LANES-1:0] en);
        int v, t;
        for (int j = 0; j < LANES; j++) begin
            if (en[j]) begin
                if (ref_cnt >= K) ref_ovf = 1;
                else begin
                    ref_cnt++;
                    v = int'(d[j*EW +: VW]);
                    t = int'(d[j*EW+VW +: IW]);
                    if (ref_hit[v]) begin
                        ref_dup[v] = 1;
                        if (LW != 0) ref_tag[v] = t;
                    end else begin
                        ref_hit[v] = 1;
                        ref_tag[v] = t;
                    end
                end
            end
        end
    endtask

    function automatic logic [SIZE*IW-1:0] exp_res();
        logic [SIZE*IW-1:0] r;
        r = '0;
        for (int i = 0; i < SIZE; i++) r[i*IW +: IW] = IW'(ref_tag[i]);
        return r;
    endfunction

    function automatic logic [SIZE-1:0] exp_hit();
        logic [SIZE-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i] = ref_hit[i];
        return r;
    endfunction

    function automatic logic [SIZE-1:0] exp_dup();
        logic [SIZE-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i] = ref_dup[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
        model_clear();
        chk("load_in_ready", in_ready, 1);
        chk("load_busy", busy, 1);
    endtask

    task automatic send_beat(input logic [LANES*EW-1:0] d, input logic [LANES-1:0] en,
                             input logic last, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0; in_data = LANES*EW'($urandom); in_lane_en = '1; in_last = 1'b1;
            tick();
        end
        in_valid = 1'b1; in_data = d; in_lane_en = en; in_last = last;
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_lane_en = '0;
        model_beat(d, en);
    endtask

    task automatic check_table(input string name);
        chk({name, "_out_valid"}, out_valid, 1);
        chk({name, "_in_ready"}, in_ready, 0);
        chk({name, "_hit"}, hit_mask, exp_hit());
        chk({name, "_results"}, results, exp_res());
        chk({name, "_overflow"}, overflow, ref_ovf);
`ifdef ARRAY_SEL_DUP_DETECT_EN
        chk({name, "_dup"}, dup_mask, exp_dup());
`endif
    endtask

    task automatic finish_frame(input int delay);
        out_ready = 1'b0;
        for (int c = 0; c < delay; c++) tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_in_ready"}, in_ready, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_hit"}, hit_mask, 0);
        chk({name, "_results"}, results, 0);
        chk({name, "_overflow"}, overflow, 0);
    endtask

    initial begin
        logic [SIZE*IW-1:0] hold_res;
        int nb;
        rst_n = 1'b0; start = 0; in_valid = 0; in_last = 0; out_ready = 0;
        in_data = '0; in_lane_en = '0;
        model_clear();
        #12;
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // IDLE must not accept beats.
        in_valid = 1'b1; in_lane_en = '1; in_data = {3'd7, 4'd3, 3'd6, 4'd4}; in_last = 1'b1;
        tick(); tick();
        in_valid = 1'b0; in_last = 1'b0;
        check_zero("idle_ignore");

        // Basic frame.
        do_start();
        send_beat({3'd1, 4'd2, 3'd0, 4'd5}, 2'b11, 1'b0, 0);
        chk("basic_not_done", out_valid, 0);
        send_beat({3'd3, 4'd0, 3'd2, 4'd9}, 2'b11, 1'b1, 0);
        check_table("basic");
        chk("basic_hit_const", hit_mask, 16'h0225);
        chk("basic_bin0", results[0*IW +: IW], 3);
        chk("basic_bin2", results[2*IW +: IW], 1);
        chk("basic_bin5", results[5*IW +: IW], 0);
        chk("basic_bin9", results[9*IW +: IW], 2);
        finish_frame(0);

        // Collision on bin 7, within a beat and across beats.
        do_start();
        send_beat({3'd6, 4'd7, 3'd4, 4'd7}, 2'b11, 1'b0, 0);
        send_beat({3'd0, 4'd1, 3'd1, 4'd7}, 2'b01, 1'b1, 0);
        check_table("collide");
        chk("collide_bin7", results[7*IW +: IW], (LW != 0) ? 1 : 4);
`ifdef ARRAY_SEL_DUP_DETECT_EN
        chk("collide_dup7", dup_mask[7], 1);
`endif
        finish_frame(1);

        // Overflow: 10 entries into an 8-entry frame.
        do_start();
        for (int b = 0; b < 5; b++)
            send_beat(LANES*EW'($urandom), 2'b11, (b == 4), 0);
        check_table("ovf");
        chk("ovf_const", overflow, 1);
        finish_frame(0);

        // Backpressure in DONE: stable outputs, start and beats ignored.
        do_start();
        send_beat(LANES*EW'($urandom), 2'b11, 1'b0, 0);
        send_beat(LANES*EW'($urandom), 2'b10, 1'b1, 0);
        check_table("bp");
        hold_res = exp_res();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            in_valid = 1'b1; in_lane_en = '1; in_last = 1'b1;
            in_data = LANES*EW'($urandom);
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_results", results, hold_res);
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check_table("bp_end");
        finish_frame(0);

        // Reset mid-LOAD aborts; next frame starts clean.
        do_start();
        send_beat({3'd5, 4'd11, 3'd2, 4'd13}, 2'b11, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        #3 rst_n = 1'b1;
        model_clear();
        tick();
        do_start();
        send_beat({3'd1, 4'd6, 3'd0, 4'd3}, 2'b01, 1'b1, 0);
        check_table("post_reset");
        chk("post_reset_hit", hit_mask, 16'h0008);
        finish_frame(0);

        // Empty frame.
        do_start();
        send_beat(LANES*EW'($urandom), 2'b00, 1'b1, 0);
        check_table("empty");
        chk("empty_hit", hit_mask, 0);
        chk("empty_results", results, 0);
        finish_frame(0);

        // Random frames with input gaps and output backpressure.
        for (int f = 0; f < 20; f++) begin
            do_start();
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++)
                send_beat(LANES*EW'($urandom), LANES'($urandom), (b == nb - 1),
                          $urandom_range(0, 2));
            check_table("rand");
            finish_frame($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
